dmem_arb: RTL
=============

DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 Parameter: LOCK_MAX, default 8, maximum consecutive port-1 grants held by lock while port 0 is waiting.
REQ-002 Reset: one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  system clock, all state on rising edge.
REQ-004 rst  in  1  synchronous reset, active-low (asserted at 0).
REQ-005 m0_req  in  1  port 0 (core LSU) access request.
REQ-006 m0_addr  in  32  port 0 byte address.
REQ-007 m0_we  in  2  port 0 write enables: 00 load, 01 byte, 10 half, 11 word.
REQ-008 m0_wdata  in  32  port 0 store data.
REQ-009 m0_gnt  out  1  port 0 access accepted this cycle.
REQ-010 m0_rvalid  out  1  port 0 load data valid.
REQ-011 m0_rdata  out  32  port 0 load data.
REQ-012 m1_req, m1_addr, m1_we, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: port 1 (debug/DMA), same widths and meanings as port 0.
REQ-013 m1_lock  in  1  port 1 requests back-to-back ownership.
REQ-014 d_addr  out  32  data memory address.
REQ-015 d_we  out  2  data memory write enables, same encoding as mX_we.
REQ-016 d_wr_data  out  32  data memory write data.
REQ-017 d_rd_data  in  32  data memory read data, valid one cycle after address.

Function
REQ-018 Grant and memory outputs SHALL be combinational from current requests and state; accepted access is presented to memory in the same cycle.
REQ-019 At most one of m0_gnt/m1_gnt SHALL be 1 per cycle; mX_gnt SHALL never be 1 while mX_req is 0.
REQ-020 Single requester SHALL be granted unconditionally.
REQ-021 No grant: d_we SHALL be 00, d_addr and d_wr_data SHALL be 0.
REQ-022 Granted port's addr/we/wdata SHALL drive d_addr/d_we/d_wr_data unmodified.
REQ-023 Granted load (we=00) SHALL set registered rd_pend=1 and rd_owner=granted port; next cycle the owner's rvalid=1 and rdata=d_rd_data; the other port's rvalid=0.
REQ-024 Granted store SHALL produce no rvalid; rdata outputs SHALL be d_rd_data regardless (don't-care when rvalid=0).
REQ-025 Back-to-back loads SHALL be supported every cycle; rvalid for cycle N's grant appears in cycle N+1 independent of cycle N+1's grant.
REQ-026 Lock: if port 1 was granted last cycle with m1_lock=1, and m1_req=1 and m1_lock=1 now, port 1 SHALL win over port 0.
REQ-027 lock_cnt SHALL increment on each locked port-1 grant with m0_req=1, and clear on any port-0 grant or any cycle m1_lock=0.
REQ-028 When lock_cnt reaches LOCK_MAX and m0_req=1, port 0 SHALL be granted that cycle, overriding lock; lock_cnt clears.
REQ-029 Both requesting, no active lock: priority per Configuration.
REQ-030 last_gnt register SHALL record the port granted, unchanged on idle cycles.

Reset
REQ-031 With rst=0 at a rising edge: rd_pend=0, rd_owner=0, last_gnt=1, lock_cnt=0.
REQ-032 During and after reset: m0_rvalid=m1_rvalid=0; grants follow REQ-018..020 combinationally, but any grant in a cycle with rst=0 SHALL not set rd_pend.
REQ-033 Reset asserted while a load is pending SHALL drop its rvalid; no response is issued for it.

Configuration
REQ-034 Macro DMEM_ARB_RR_EN defined: contention resolved round-robin -- grant the port not equal to last_gnt (after reset port 0 wins first).
REQ-035 DMEM_ARB_RR_EN undefined: port 0 always wins contention; lock and LOCK_MAX override still apply.

Verification
REQ-036 Reset, then m0 load addr 0x100 alone, mem returns 0xDEADBEEF -> m0_gnt=1 cycle 0, m0_rvalid=1 rdata=0xDEADBEEF cycle 1, m1_rvalid=0.
REQ-037 Both req every cycle, RR on, m0/m1 loads -> grants alternate 0,1,0,1; rvalid alternates one cycle later with matching data.
REQ-038 Both req, RR off -> m0_gnt=1 every cycle, m1_gnt=0; drop m0_req -> m1 granted same cycle.
REQ-039 m1 locked word stores 0x200.., m0_req held, LOCK_MAX=8 -> m1 granted 8 cycles (d_we=11), then m0 granted in 9th cycle.
REQ-040 m0 load granted, rst=0 next cycle -> no m0_rvalid; after release idle -> d_we=00, d_addr=0, no grants.

Source files
------------

// File: rtl/dmem_arb.sv
// dmem_arb: two-port data memory arbiter, port 0 = core LSU, port 1 = debug/DMA.
// Latency: grant and memory request are combinational; load data returns one cycle after the grant.
// Backpressure: a losing requester sees gnt=0 and must hold its request; nothing is queued inside.
// Build option: define DMEM_ARB_RR_EN for round-robin contention; otherwise port 0 has fixed priority.
module dmem_arb #(
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  // port 0 (core LSU)
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [1:0]  m0_we,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  // port 1 (debug/DMA)
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [1:0]  m1_we,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  // data memory
  output logic [31:0] d_addr,
  output logic [1:0]  d_we,
  output logic [31:0] d_wr_data,
  input  logic [31:0] d_rd_data
);

  // Counter must be able to hold LOCK_MAX itself; keep at least one bit.
  localparam int unsigned CNT_W = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(LOCK_MAX);

  // Registered state
  logic             r_rd_pend;      // a load was accepted last cycle
  logic             r_rd_owner;     // port that owns the pending load
  logic             r_last_gnt;     // port of the most recent grant (held over idle cycles)
  logic             r_gnt_lock_prev;// last cycle had a grant while m1_lock was high
  logic [CNT_W-1:0] r_lock_cnt;     // consecutive locked port-1 grants that made port 0 wait

  // Combinational decisions
  logic w_both;
  logic w_lock_active;
  logic w_lock_expire;
  logic w_cont_pick1;
  logic w_gnt0;
  logic w_gnt1;
  logic w_any_gnt;
  logic w_load;

  // Contention winner when neither lock nor lock expiry applies.
`ifdef DMEM_ARB_RR_EN
  // Round-robin: hand the bus to the port that did not win last time.
  assign w_cont_pick1 = ~r_last_gnt;
`else
  // Fixed priority: port 0 always wins a plain tie.
  assign w_cont_pick1 = 1'b0;
`endif

  // Lock holds only if port 1 itself won the previous cycle with lock asserted;
  // r_last_gnt tells which port that previous grant went to.
  assign w_lock_active = r_gnt_lock_prev & r_last_gnt & m1_req & m1_lock;
  // Port 0 has waited LOCK_MAX locked cycles: it takes the bus regardless of lock.
  assign w_lock_expire = m0_req & (r_lock_cnt >= LOCK_LIMIT);
  assign w_both        = m0_req & m1_req;

  // Grant selection: lock expiry, then lock, then contention policy, then lone requester.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_lock_expire) begin
      w_gnt0 = 1'b1;
    end else if (w_lock_active) begin
      w_gnt1 = 1'b1;
    end else if (w_both) begin
      w_gnt0 = ~w_cont_pick1;
      w_gnt1 = w_cont_pick1;
    end else begin
      w_gnt0 = m0_req;
      w_gnt1 = m1_req;
    end
  end

  assign w_any_gnt = w_gnt0 | w_gnt1;
  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;

  // Memory request mux: the granted port passes straight through, idle drives zeros.
  always_comb begin
    d_addr    = 32'h0;
    d_we      = 2'b00;
    d_wr_data = 32'h0;
    if (w_gnt0) begin
      d_addr    = m0_addr;
      d_we      = m0_we;
      d_wr_data = m0_wdata;
    end else if (w_gnt1) begin
      d_addr    = m1_addr;
      d_we      = m1_we;
      d_wr_data = m1_wdata;
    end
  end

  // A granted access with no write enables is a load and expects a response.
  assign w_load = w_any_gnt & (d_we == 2'b00);

  // Read-response tracking; a grant during reset never creates a pending load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= 1'b0;
    end else begin
      r_rd_pend <= w_load;
      if (w_load) begin
        r_rd_owner <= w_gnt1;
      end
    end
  end

  // Remember who was granted last; idle cycles leave it alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_gnt <= 1'b1;
    end else if (w_any_gnt) begin
      r_last_gnt <= w_gnt1;
    end
  end

  // Flag a grant that happened with lock requested, so the next cycle can honour the lock.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_gnt_lock_prev <= 1'b0;
    end else begin
      r_gnt_lock_prev <= w_any_gnt & m1_lock;
    end
  end

  // Count how long port 0 has been starved by a locked port 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lock_cnt <= '0;
    end else if (w_gnt0 || !m1_lock) begin
      r_lock_cnt <= '0;
    end else if (w_gnt1 && m0_req && (r_lock_cnt != LOCK_LIMIT)) begin
      r_lock_cnt <= r_lock_cnt + CNT_W'(1);
    end
  end

  // Responses: data is the raw memory output; valid is suppressed while reset is held,
  // which also discards a load that was pending when reset arrived.
  assign m0_rvalid = rst & r_rd_pend & ~r_rd_owner;
  assign m1_rvalid = rst & r_rd_pend & r_rd_owner;
  assign m0_rdata  = d_rd_data;
  assign m1_rdata  = d_rd_data;

endmodule
